// File: rtl/rv32_pkg.sv
// Shared RV32I encodings, ALU/immediate enums and decode helpers for the
// 10-bit-address core.
package rv32_pkg;

  localparam int PC_W = 10;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LW = 3'd2;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

  // alt selects SUB / SRA; callers only assert it where those exist.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dmem_1kx32.sv
// Data memory: combinational read, write on the rising edge when we is high.
module dmem_1kx32 #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/decode_execute_unit.sv
// Decode/execute/memory stage: one decode register, bypassed operand read,
// ALU + branch resolution and registered write-back/redirect outputs.
module decode_execute_unit
  import rv32_pkg::*;
#(
  parameter int DMEM_WORDS = 1024,
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             instr_valid,
  input  logic [31:0]      instruction,
  input  logic [PC_W-1:0]  pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             rd_we,
  output logic [4:0]       rd_addr,
  output logic [XLEN-1:0]  rd_data,
  output logic             branch,
  output logic [PC_W-1:0]  target_address
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic            d_valid_reg;
  logic [31:0]     d_instr_reg;
  logic [PC_W-1:0] d_pc_reg;
  logic            rd_we_reg;
  logic [4:0]      rd_addr_reg;
  logic [XLEN-1:0] rd_data_reg;
  logic            branch_reg;
  logic [PC_W-1:0] target_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode   = d_instr_reg[6:0];
  assign rd       = d_instr_reg[11:7];
  assign funct3   = d_instr_reg[14:12];
  assign funct7   = d_instr_reg[31:25];
  assign rs1_addr = d_instr_reg[19:15];
  assign rs2_addr = d_instr_reg[24:20];

  logic     legal, use_imm, writes_rd;
  logic     is_branch, is_jal, is_jalr, is_load, is_store;
  alu_op_e  alu_op;
  imm_fmt_e imm_fmt;

  always_comb begin
    legal     = 1'b0;
    use_imm   = 1'b0;
    writes_rd = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    alu_op    = ALU_ADD;
    imm_fmt   = IMM_I;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; writes_rd = 1'b1; use_imm = 1'b1;
        imm_fmt = IMM_U; alu_op = ALU_PASS_B;
      end
      OPC_JAL: begin
        legal = 1'b1; writes_rd = 1'b1; is_jal = 1'b1; imm_fmt = IMM_J;
      end
      OPC_JALR: begin
        legal = (funct3 == 3'd0); writes_rd = 1'b1; is_jalr = 1'b1; use_imm = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (funct3 != 3'd2) && (funct3 != 3'd3); is_branch = 1'b1; imm_fmt = IMM_B;
      end
      OPC_LOAD: begin
        legal = (funct3 == F3_LW); writes_rd = 1'b1; is_load = 1'b1; use_imm = 1'b1;
      end
      OPC_STORE: begin
        legal = (funct3 == F3_SW); is_store = 1'b1; use_imm = 1'b1; imm_fmt = IMM_S;
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1; use_imm = 1'b1;
        // Shift-immediates reuse the upper immediate bits as funct7.
        case (funct3)
          F3_SLL:  legal = (funct7 == F7_BASE);
          F3_SR:   legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
        alu_op = alu_decode(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
        alu_op = alu_decode(funct3, funct7 == F7_ALT);
      end
      default: legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] rs1_val, rs2_val, imm, op_b, alu_result, mem_rdata, wb_data, link;
  logic [4:0]      shamt;

  assign rs1_val = (rs1_addr == 5'd0) ? '0 :
                   (rd_we_reg && (rd_addr_reg == rs1_addr)) ? rd_data_reg : rs1_data;
  assign rs2_val = (rs2_addr == 5'd0) ? '0 :
                   (rd_we_reg && (rd_addr_reg == rs2_addr)) ? rd_data_reg : rs2_data;

  assign imm   = imm_gen(d_instr_reg, imm_fmt);
  assign op_b  = use_imm ? imm : rs2_val;
  assign shamt = op_b[4:0];

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_result = rs1_val + op_b;
      ALU_SUB:  alu_result = rs1_val - op_b;
      ALU_SLL:  alu_result = rs1_val << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(op_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, rs1_val < op_b};
      ALU_XOR:  alu_result = rs1_val ^ op_b;
      ALU_SRL:  alu_result = rs1_val >> shamt;
      ALU_SRA:  alu_result = $signed(rs1_val) >>> shamt;
      ALU_OR:   alu_result = rs1_val | op_b;
      ALU_AND:  alu_result = rs1_val & op_b;
      default:  alu_result = op_b;
    endcase
  end

  logic br_cond;
  always_comb begin
    case (funct3)
      F3_BEQ:  br_cond = (rs1_val == rs2_val);
      F3_BNE:  br_cond = (rs1_val != rs2_val);
      F3_BLT:  br_cond = $signed(rs1_val) < $signed(rs2_val);
      F3_BGE:  br_cond = $signed(rs1_val) >= $signed(rs2_val);
      F3_BLTU: br_cond = rs1_val < rs2_val;
      F3_BGEU: br_cond = rs1_val >= rs2_val;
      default: br_cond = 1'b0;
    endcase
  end

  logic            take, wb_we, store_we;
  logic [PC_W-1:0] target_next;

  assign take = d_valid_reg && legal && (is_jal || is_jalr || (is_branch && br_cond));
  // Immediates are byte offsets; bits [PC_W+1:2] give the word-index offset.
  assign target_next = is_jalr ? alu_result[PC_W+1:2] : d_pc_reg + imm[PC_W+1:2];
  assign link = {{(XLEN-PC_W-2){1'b0}}, d_pc_reg + {{(PC_W-1){1'b0}}, 1'b1}, 2'b00};

  assign wb_we    = d_valid_reg && legal && writes_rd && (rd != 5'd0);
  assign store_we = d_valid_reg && legal && is_store && !Reset;
  assign wb_data  = is_load ? mem_rdata : (is_jal || is_jalr) ? link : alu_result;

  dmem_1kx32 #(.DEPTH(DMEM_WORDS), .WIDTH(XLEN)) u_dmem (
    .clk   (clk),
    .we    (store_we),
    .addr  (alu_result[AW+1:2]),
    .wdata (rs2_val),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    d_instr_reg <= instruction;
    d_pc_reg    <= pc;
    if (Reset) begin
      d_valid_reg <= 1'b0;
      rd_we_reg   <= 1'b0;
      rd_addr_reg <= '0;
      rd_data_reg <= '0;
      branch_reg  <= 1'b0;
      target_reg  <= '0;
    end else begin
      // The slot captured alongside a taken transfer is the wrong-path instruction.
      d_valid_reg <= instr_valid && !take;
      rd_we_reg   <= wb_we;
      rd_addr_reg <= rd;
      rd_data_reg <= wb_data;
      branch_reg  <= take;
      if (take) target_reg <= target_next;
    end
  end

  assign rd_we          = rd_we_reg;
  assign rd_addr        = rd_addr_reg;
  assign rd_data        = rd_data_reg;
  assign branch         = branch_reg;
  assign target_address = target_reg;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed + random bench for decode_execute_unit with an instruction-level
// reference model and a behavioural external register file.
module tb_decode_execute_unit;

  logic        clk;
  logic        Reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [9:0]  pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        branch;
  logic [9:0]  target_address;

  decode_execute_unit #(.DMEM_WORDS(1024), .XLEN(32)) dut (
    .clk            (clk),
    .Reset          (Reset),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .pc             (pc),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .rd_we          (rd_we),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .branch         (branch),
    .target_address (target_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External register file: commits write-back one edge after it appears.
  logic [31:0] regs [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (!Reset && rd_we) regs[rd_addr] <= rd_data;
  end
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  typedef struct {
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        br;
    logic [9:0]  tgt;
  } exp_t;

  exp_t        q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_txn    = 0;
  logic [31:0] ref_regs [32];
  logic [31:0] ref_mem  [1024];
  logic        written  [16];
  logic        squash;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic br, input logic [9:0] tgt);
    exp_t e;
    e.instr = 32'h0; e.we = we; e.rd = rd; e.data = data; e.br = br; e.tgt = tgt;
    return e;
  endfunction

  // Architectural execution of one slot, in program order.
  task automatic model_exec(input logic v, input logic [31:0] ins, input logic [9:0] p, output exp_t e);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, sh;
    logic [31:0] a, b, iimm, simm, bimm, jimm, val, ea;
    logic        wr, taken;
    logic [9:0]  tgt;
    e = mk(1'b0, 5'd0, 32'h0, 1'b0, 10'd0);
    e.instr = ins;
    if (!v || squash) begin
      squash = 1'b0;
      return;
    end
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
    a = ref_regs[ins[19:15]]; b = ref_regs[ins[24:20]];
    iimm = {{20{ins[31]}}, ins[31:20]};
    simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    sh = ins[24:20];
    wr = 1'b0; taken = 1'b0; tgt = 10'd0; val = 32'h0;
    case (op)
      7'h37: begin wr = 1'b1; val = {ins[31:12], 12'h0}; end
      7'h6f: begin
        wr = 1'b1; val = {20'h0, 10'(int'(p) + 1), 2'b00};
        taken = 1'b1; tgt = 10'(int'(p) + ($signed(jimm) >>> 2));
      end
      7'h67: if (f3 == 3'd0) begin
        wr = 1'b1; val = {20'h0, 10'(int'(p) + 1), 2'b00};
        taken = 1'b1; tgt = 10'($signed(a + iimm) >>> 2);
      end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = $signed(a) < $signed(b);
          3'd5: taken = $signed(a) >= $signed(b);
          3'd6: taken = a < b;
          3'd7: taken = a >= b;
          default: taken = 1'b0;
        endcase
        tgt = 10'(int'(p) + ($signed(bimm) >>> 2));
      end
      7'h03: if (f3 == 3'd2) begin
        ea = a + iimm; wr = 1'b1; val = ref_mem[ea[11:2]];
      end
      7'h23: if (f3 == 3'd2) begin
        ea = a + simm; ref_mem[ea[11:2]] = b;
        if (ea[11:2] < 10'd16) written[ea[5:2]] = 1'b1;
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0: val = a + iimm;
          3'd2: val = ($signed(a) < $signed(iimm)) ? 32'd1 : 32'd0;
          3'd3: val = (a < iimm) ? 32'd1 : 32'd0;
          3'd4: val = a ^ iimm;
          3'd6: val = a | iimm;
          3'd7: val = a & iimm;
          3'd1: if (f7 == 7'h00) val = a << sh; else wr = 1'b0;
          default: begin
            if (f7 == 7'h00) val = a >> sh;
            else if (f7 == 7'h20) val = 32'($signed(a) >>> sh);
            else wr = 1'b0;
          end
        endcase
      end
      7'h33: begin
        wr = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: val = a + b;
          {7'h20, 3'd0}: val = a - b;
          {7'h00, 3'd1}: val = a << b[4:0];
          {7'h00, 3'd2}: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd3}: val = (a < b) ? 32'd1 : 32'd0;
          {7'h00, 3'd4}: val = a ^ b;
          {7'h00, 3'd5}: val = a >> b[4:0];
          {7'h20, 3'd5}: val = 32'($signed(a) >>> b[4:0]);
          {7'h00, 3'd6}: val = a | b;
          {7'h00, 3'd7}: val = a & b;
          default: wr = 1'b0;
        endcase
      end
      default: wr = 1'b0;
    endcase
    e.we = wr && (rd != 5'd0);
    if (e.we) ref_regs[rd] = val;
    e.rd = rd; e.data = val; e.br = taken; e.tgt = tgt;
    squash = taken;
  endtask

  task automatic check_entry(input exp_t e);
    chk("rd_we", {31'h0, rd_we}, {31'h0, e.we});
    if (e.we) begin
      chk("rd_addr", {27'h0, rd_addr}, {27'h0, e.rd});
      chk("rd_data", rd_data, e.data);
    end
    chk("branch", {31'h0, branch}, {31'h0, e.br});
    if (e.br) chk("target_address", {22'h0, target_address}, {22'h0, e.tgt});
    $display("txn %0d instr=%08h rd_we=%0b rd=%0d data=%08h branch=%0b target=%0d",
             n_txn, e.instr, rd_we, rd_addr, rd_data, branch, target_address);
    n_txn++;
  endtask

  // Called at a falling edge: check the slot driven two edges ago, then drive the next.
  task automatic step(input logic v, input logic [31:0] ins, input logic [9:0] p,
                      input logic use_d, input exp_t d);
    exp_t e;
    if (q.size() >= 2) check_entry(q.pop_front());
    instr_valid = v; instruction = ins; pc = p;
    model_exec(v, ins, p, e);
    if (use_d) begin
      d.instr = ins;
      e = d;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [2:0]  bf [6];
    logic [11:0] i12, s12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [6:0]  f7;
    int          k, off, w;
    int          list[$];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    i12 = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
    k = $urandom_range(0, 99);
    if (k < 20) begin
      if (f3 == 3'd1) i12 = {7'h00, i12[4:0]};
      else if (f3 == 3'd5) i12 = {(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00), i12[4:0]};
      return {i12, rs1, f3, rd, 7'h13};
    end else if (k < 40) begin
      f7 = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) != 0)) ? 7'h20 : 7'h00;
      return {f7, rs2, rs1, f3, rd, 7'h33};
    end else if (k < 48) begin
      return {20'($urandom), rd, 7'h37};
    end else if (k < 56) begin
      off = (int'($urandom_range(0, 32)) - 16) * 4;
      b13 = 13'(off);
      return {b13[12], b13[10:5], rs2, rs1, bf[$urandom_range(0, 5)], b13[4:1], b13[11], 7'h63};
    end else if (k < 60) begin
      off = (int'($urandom_range(0, 32)) - 16) * 4;
      j21 = 21'(off);
      return {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6f};
    end else if (k < 64) begin
      return {i12, rs1, 3'b000, rd, 7'h67};
    end else if (k < 74) begin
      w = $urandom_range(0, 15);
      s12 = 12'(w * 4);
      return {s12[11:5], rs2, 5'd0, 3'b010, s12[4:0], 7'h23};
    end else if (k < 84) begin
      for (int i = 0; i < 16; i++) if (written[i]) list.push_back(i);
      if (list.size() == 0) return {i12, rs1, 3'b000, rd, 7'h13};
      w = list[$urandom_range(0, list.size() - 1)];
      return {12'(w * 4), 5'd0, 3'b010, rd, 7'h03};
    end else if (k < 92) begin
      case ($urandom_range(0, 3))
        0: return {20'($urandom), rd, 7'h17};
        1: return {7'h01, rs2, rs1, f3, rd, 7'h33};
        2: return {i12, rs1, 3'b000, rd, 7'h03};
        default: return {7'h20, i12[4:0], rs1, 3'b001, rd, 7'h13};
      endcase
    end
    return {i12, rs1, 3'b000, rd, 7'h13};
  endfunction

  initial begin
    exp_t none;
    none = mk(1'b0, 5'd0, 32'h0, 1'b0, 10'd0);
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) written[i] = 1'b0;
    squash = 1'b0;

    Reset = 1'b1; instr_valid = 1'b1; instruction = 32'h00500093; pc = 10'd0;
    repeat (2) @(negedge clk);
    chk("reset rd_we", {31'h0, rd_we}, 32'h0);
    chk("reset rd_addr", {27'h0, rd_addr}, 32'h0);
    chk("reset rd_data", rd_data, 32'h0);
    chk("reset branch", {31'h0, branch}, 32'h0);
    chk("reset target", {22'h0, target_address}, 32'h0);
    Reset = 1'b0;

    step(1'b1, 32'h00500093, 10'd0, 1'b1, mk(1'b1, 5'd1, 32'd5,  1'b0, 10'd0));
    step(1'b1, 32'h00108133, 10'd1, 1'b1, mk(1'b1, 5'd2, 32'd10, 1'b0, 10'd0));
    step(1'b1, 32'h00202423, 10'd2, 1'b1, mk(1'b0, 5'd0, 32'd0,  1'b0, 10'd0));
    step(1'b1, 32'h00802183, 10'd3, 1'b1, mk(1'b1, 5'd3, 32'd10, 1'b0, 10'd0));
    step(1'b1, 32'h00000863, 10'd4, 1'b1, mk(1'b0, 5'd0, 32'd0,  1'b1, 10'd8));
    step(1'b1, 32'h00500093, 10'd5, 1'b1, none);
    step(1'b1, 32'h008000ef, 10'd3, 1'b1, mk(1'b1, 5'd1, 32'd16, 1'b1, 10'd5));
    step(1'b1, 32'h00700013, 10'd5, 1'b1, none);
    step(1'b1, 32'h00700013, 10'd5, 1'b1, none);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) != 0), gen_instr(), 10'($urandom), 1'b0, none);
    end
    step(1'b0, 32'h0, 10'd0, 1'b0, none);
    step(1'b0, 32'h0, 10'd0, 1'b0, none);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_execute_unit.md
# decode_execute_unit

Decode, execute and data-memory stages of the 10-bit-address RV32I core. The block sits between the fetch unit and the external register file. It registers each fetched instruction and decodes it, reads operands through an external combinational register-file port with an internal bypass, and executes ALU/branch/jump/load/store operations. It owns the 1024×32 data memory and returns registered write-back and redirect signals.

## Interface
- Parameter DMEM_WORDS, 1024: data memory depth in 32-bit words (index width 10).
- Parameter XLEN, 32: datapath width.
- clk  in  1  single clock, all state on rising edge.
- Reset  in  1  reset, synchronous and active-high.
- instr_valid  in  1  instruction/pc qualify this cycle.
- instruction  in  32  RV32I encoding.
- pc  in  10  word index of instruction.
- rs1_addr, rs2_addr  out  5  each; register-file read addresses, combinational from the decode register.
- rs1_data, rs2_data  in  32  each; combinational register-file read data.
- rd_we  out  1  registered write-back enable.
- rd_addr  out  5  registered write-back register.
- rd_data  out  32  registered write-back value.
- branch  out  1  registered taken-transfer pulse.
- target_address  out  10  registered redirect word index.

## Operation
- Decode register captures instr_valid/instruction/pc every edge. The captured valid is forced to 0 when branch is 1 at that edge (squash).
- Supported: LUI; JAL; JALR; BEQ/BNE/BLT/BGE/BLTU/BGEU; LW; SW; ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI; ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. Any other opcode or funct is a NOP: no write, no branch, no store.
- Immediates are sign-extended to 32 bits per RV32I format. Shifts use operand bits [4:0]. Arithmetic wraps modulo 2^32.
- Operand bypass: if the E output has rd_we=1 and rd_addr equals rs1/rs2 (nonzero), the block uses rd_data instead of rs*_data. Register 0 always reads 0.
- Branch/JAL target = pc + (sext(imm) >>> 2), truncated to 10 bits.
- JALR target = ((rs1 + sext(imm)) >>> 2)[9:0].
- JAL/JALR link value = {20'b0, (pc+1), 2'b00}.
- Data address: effective byte address ea = rs1 + sext(imm); word index = ea[11:2]; ea[1:0] ignored.
- LW: asynchronous memory read in the E cycle; the value is registered into rd_data.
- SW: writes rs2 to memory at the edge ending the E cycle; rd_we=0.
- rd_we is forced 0 when rd=0, for stores, branches, NOPs and squashed instructions.
- Memory contents are not affected by Reset and are zero at power-up.

## Timing
- Latency: instruction accepted at edge k. The result is visible on rd_*/branch/target_address after edge k+1. The external register file commits it at edge k+2.
- Throughput: one instruction per cycle with no stalls. Load-use needs no stall because the read is combinational within E.
- branch is high for exactly one cycle per taken branch/jump. During that cycle fetch drives the target instruction. The instruction captured at the edge where branch rose is squashed, giving a one-instruction bubble.
- Store followed by a load to the same word in the next instruction returns the new data.
- Back-to-back dependent ALU ops use the bypass. An instruction two slots later reads the committed register file.
- Reset at any edge clears decode valid, rd_we, rd_addr, rd_data, branch and target_address to 0. Any in-flight store at that edge is dropped.

## Structure
- Shared package `rv32_pkg`: 7-bit opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI), funct3 codes, ALU-op enum and immediate-format enum.
- One sub-module `dmem_1kx32`: asynchronous read, synchronous write-enable, DMEM_WORDS×32.
- Decode, bypass, ALU, branch compare and write-back registers live in the top module.

## Test plan
- Hold Reset 2 cycles with instr_valid=1 -> rd_we=0, branch=0, target_address=0, rd_data=0.
- ADDI x1,x0,5 (0x00500093) at pc 0 -> after the second edge rd_we=1, rd_addr=1, rd_data=5.
- ADDI x1,x0,5 then ADD x2,x1,x1 (0x00108133) with rs*_data held 0 -> rd_addr=2, rd_data=10 via the bypass.
- SW x2,8(x0) (0x00202423) with rs2_data=10, then LW x3,8(x0) (0x00802183) -> SW has rd_we=0; LW gives rd_addr=3, rd_data=10 (word 2).
- BEQ x0,x0,+16 (0x00000863) at pc 4 followed by ADDI x1,x0,5 -> branch=1 for one cycle, target_address=8, and the ADDI produces rd_we=0.
- JAL x1,+8 (0x008000EF) at pc 3 -> branch=1, target_address=5, rd_addr=1, rd_data=16. ADDI x0,x0,7 -> rd_we=0.
